rps_referee: RTL and testbench

- Downstream consumer of the CPU move generator: takes the player's 2-bit move (debounced switch input) and the generator's current 2-bit move.
- Judges each round of rock-paper-scissors and keeps both scores.
- Runs a first-to-WIN_SCORE match and holds the round result for the display stage.
- Sits between the move generator / switch-capture logic and the seven-segment/LED display driver.

---
 rtl/rps_referee.sv | 168 ++++++++++++++++
 tb/tb_rps_referee.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rps_referee.sv
// Rock-paper-scissors referee: judges rounds, keeps scores,
// runs a first-to-WIN_SCORE match and holds results for display.
module rps_referee #(
  parameter int WIN_SCORE     = 3,
  parameter int SCORE_W       = 3,
  parameter int REVEAL_CYCLES = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [1:0]         Player_move,
  input  logic               Player_valid,
  input  logic [1:0]         Cpu_move,
  input  logic               New_match,
  output logic               Ready,
  output logic [1:0]         Result,
  output logic               Result_valid,
  output logic [1:0]         Shown_player,
  output logic [1:0]         Shown_cpu,
  output logic [SCORE_W-1:0] Player_score,
  output logic [SCORE_W-1:0] Cpu_score,
  output logic               Match_over,
  output logic               Match_winner,
  output logic               Bad_move
);

  localparam int CNT_W =
    (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(REVEAL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, JUDGE, REVEAL, OVER
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sp_q, sp_d;
  logic [1:0]         sc_q, sc_d;
  logic [1:0]         res_q, res_d;
  logic               rv_q, rv_d;
  logic [SCORE_W-1:0] ps_q, ps_d;
  logic [SCORE_W-1:0] cs_q, cs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               over_q, over_d;
  logic               win_q, win_d;
  logic               bad_q, bad_d;

  logic [1:0] p_inc, c_inc;
  logic       p_win, c_win;

  // Successor mod 3 on the latched moves
  assign p_inc = (sp_q == 2'd2) ? 2'd0 : sp_q + 2'd1;
  assign c_inc = (sc_q == 2'd2) ? 2'd0 : sc_q + 2'd1;
  assign p_win = (sp_q == c_inc);
  assign c_win = (sc_q == p_inc);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sp_q    <= '0;
      sc_q    <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      ps_q    <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      sc_q    <= sc_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      ps_q    <= ps_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    sc_d    = sc_q;
    res_d   = res_q;
    rv_d    = 1'b0;
    ps_d    = ps_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    win_d   = win_q;
    bad_d   = 1'b0;
    if (New_match) begin
      state_d = IDLE;
      sp_d    = '0;
      sc_d    = '0;
      res_d   = '0;
      ps_d    = '0;
      cs_d    = '0;
      cnt_d   = '0;
      over_d  = 1'b0;
      win_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Player_valid) begin
            if (Player_move == 2'b11) begin
              bad_d = 1'b1;
            end else begin
              sp_d    = Player_move;
              sc_d    = (Cpu_move == 2'b11) ? 2'b00 : Cpu_move;
              state_d = JUDGE;
            end
          end
        end
        JUDGE: begin
          rv_d    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = REVEAL;
          if (p_win) begin
            res_d = 2'b01;
            ps_d  = ps_q + 1'b1;
          end else if (c_win) begin
            res_d = 2'b10;
            cs_d  = cs_q + 1'b1;
          end else begin
            res_d = 2'b11;
          end
        end
        REVEAL: begin
          if (cnt_q == '0) begin
            if (ps_q == WIN || cs_q == WIN) begin
              state_d = OVER;
              over_d  = 1'b1;
              win_d   = (ps_q == WIN);
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign Ready        = (state_q == IDLE);
  assign Result       = res_q;
  assign Result_valid = rv_q;
  assign Shown_player = sp_q;
  assign Shown_cpu    = sc_q;
  assign Player_score = ps_q;
  assign Cpu_score    = cs_q;
  assign Match_over   = over_q;
  assign Match_winner = win_q;
  assign Bad_move     = bad_q;

endmodule

// File: tb/tb_rps_referee.sv
// Directed self-checking bench for rps_referee.
// Inputs change and outputs are sampled on the falling edge.
module tb_rps_referee;

  logic       Clk;
  logic       Reset;
  logic [1:0] Player_move;
  logic       Player_valid;
  logic [1:0] Cpu_move;
  logic       New_match;
  logic       Ready;
  logic [1:0] Result;
  logic       Result_valid;
  logic [1:0] Shown_player;
  logic [1:0] Shown_cpu;
  logic [2:0] Player_score;
  logic [2:0] Cpu_score;
  logic       Match_over;
  logic       Match_winner;
  logic       Bad_move;

  int total = 0;
  int bad = 0;
  int n;

  rps_referee #(
    .WIN_SCORE(3), .SCORE_W(3), .REVEAL_CYCLES(4)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Player_move(Player_move), .Player_valid(Player_valid),
    .Cpu_move(Cpu_move), .New_match(New_match),
    .Ready(Ready), .Result(Result),
    .Result_valid(Result_valid),
    .Shown_player(Shown_player), .Shown_cpu(Shown_cpu),
    .Player_score(Player_score), .Cpu_score(Cpu_score),
    .Match_over(Match_over), .Match_winner(Match_winner),
    .Bad_move(Bad_move)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Drive one round strobe; returns at the falling edge after E0
  task automatic strobe(input logic [1:0] p, input logic [1:0] c);
    Player_move  = p;
    Cpu_move     = c;
    Player_valid = 1'b1;
    tick();
    Player_valid = 1'b0;
  endtask

  // Waits for Ready or Match_over; n = edges waited
  task automatic wait_rest(output int cnt);
    cnt = 0;
    while (!(Ready || Match_over) && cnt < 40) begin
      tick();
      cnt++;
    end
    if (cnt >= 40) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    Player_move = 2'b00;
    Player_valid = 1'b0;
    Cpu_move = 2'b00;
    New_match = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_ready", Ready, 1);
    chk("rst_result", Result, 0);
    chk("rst_pscore", Player_score, 0);
    chk("rst_cscore", Cpu_score, 0);
    chk("rst_over", Match_over, 0);

    // rock beats scissors
    strobe(2'b00, 2'b10);
    chk("judge_ready", Ready, 0);
    tick();
    chk("win_result", Result, 2'b01);
    chk("win_pscore", Player_score, 1);
    chk("win_rvalid", Result_valid, 1);
    chk("win_shown_c", Shown_cpu, 2'b10);
    tick();
    chk("win_rvalid_pulse", Result_valid, 0);
    wait_rest(n);
    chk("ready_latency", n + 2, 5);

    // CPU 11 folds to rock: tie
    strobe(2'b00, 2'b11);
    tick();
    chk("fold_shown_c", Shown_cpu, 2'b00);
    chk("tie_result", Result, 2'b11);
    chk("tie_pscore", Player_score, 1);
    chk("tie_cscore", Cpu_score, 0);
    wait_rest(n);
    strobe(2'b11, 2'b00);
    chk("bad_pulse", Bad_move, 1);
    chk("bad_ready", Ready, 1);
    tick();
    chk("bad_pulse_end", Bad_move, 0);
    chk("bad_result_held", Result, 2'b11);

    // paper beats rock, strobe during REVEAL is dropped
    strobe(2'b01, 2'b00);
    tick();
    chk("r2_pscore", Player_score, 2);
    strobe(2'b10, 2'b00);
    chk("busy_no_bad", Bad_move, 0);
    chk("busy_result", Result, 2'b01);
    wait_rest(n);
    tick();
    chk("busy_idle", Ready, 1);
    chk("busy_pscore", Player_score, 2);
    chk("busy_cscore", Cpu_score, 0);

    // paper beats rock three times for the CPU
    for (int r = 1; r <= 3; r++) begin
      strobe(2'b00, 2'b01);
      tick();
      chk("cpu_result", Result, 2'b10);
      chk("cpu_score", Cpu_score, r);
      wait_rest(n);
    end
    chk("over_flag", Match_over, 1);
    chk("over_winner", Match_winner, 0);
    chk("over_ready", Ready, 0);
    strobe(2'b00, 2'b10);
    tick();
    chk("over_ignore_p", Player_score, 2);
    chk("over_ignore_r", Result, 2'b10);
    chk("over_hold", Match_over, 1);
    New_match = 1'b1;
    tick();
    New_match = 1'b0;
    chk("nm_pscore", Player_score, 0);
    chk("nm_cscore", Cpu_score, 0);
    chk("nm_over", Match_over, 0);
    chk("nm_ready", Ready, 1);
    chk("nm_result", Result, 0);

    // New_match beats a simultaneous strobe
    New_match = 1'b1;
    strobe(2'b11, 2'b00);
    New_match = 1'b0;
    chk("nmpv_bad", Bad_move, 0);
    chk("nmpv_ready", Ready, 1);
    New_match = 1'b1;
    strobe(2'b01, 2'b00);
    New_match = 1'b0;
    chk("nmpv_ready2", Ready, 1);
    tick();
    chk("nmpv_rvalid", Result_valid, 0);
    chk("nmpv_result", Result, 0);

    // asynchronous reset in the middle of REVEAL
    strobe(2'b10, 2'b01);
    tick();
    chk("pre_rst_pscore", Player_score, 1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_ready", Ready, 1);
    chk("arst_result", Result, 0);
    chk("arst_rvalid", Result_valid, 0);
    chk("arst_pscore", Player_score, 0);
    chk("arst_shown", Shown_player, 0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    chk("post_rst_ready", Ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
